add_share_arbiter: RTL and testbench
====================================

Name: add_share_arbiter

Overview:
Shares one 4-bit signed adder datapath between two requesters. Each requester uses a valid/ready handshake. A round-robin arbiter grants one requester at a time. The block registers the operands, computes the 5-bit two's-complement sum, converts it to sign-magnitude BCD, and returns the tagged result through a valid/ready response channel. It sits between requester front-ends and the shared adder/BCD stage in the arithmetic subsystem.

Parameters:
RR_INIT, 0, requester that has priority after reset (0 or 1)
HOLD_MAX, 15, maximum number of cycles RESP waits for resp_ready before the result is dropped; 0 means wait forever

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operand pair
req0_a  input  4  requester 0 operand A, signed two's complement
req0_b  input  4  requester 0 operand B, signed
req0_ready  output  1  requester 0 operands accepted this cycle
req1_valid  input  1  requester 1 has an operand pair
req1_a  input  4  requester 1 operand A, signed
req1_b  input  4  requester 1 operand B, signed
req1_ready  output  1  requester 1 operands accepted this cycle
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_id  output  1  requester that owns the result
resp_sum  output  5  signed sum, a+b sign-extended, range -16..14
resp_bcd  output  6  [5]=sign, [4]=tens digit, [3:0]=ones digit of |sum|
resp_drop  output  1  one-cycle pulse: result discarded on timeout

Behaviour:
- Reset is synchronous and active-high; clk is the only clock. When rst=1 at a rising edge:
  - state becomes IDLE; all outputs become 0.
  - Priority pointer becomes RR_INIT; hold counter becomes 0.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Arbitrate among the valid requesters. If both are valid, the one matching the priority pointer wins; otherwise the single valid one wins.
  - reqN_ready is combinational and equals 1 only in IDLE, only for the winner.
  - On accept (reqN_valid & reqN_ready): latch a, b and id; the pointer moves to the other requester; go to CALC.
  - With no valid request, stay in IDLE; the pointer is unchanged.
- CALC (exactly 1 cycle):
  - Sign-extend both operands to 5 bits and add. No overflow is possible.
  - Compute the magnitude (0..16) and register sum, bcd and id.
  - BCD conversion: if magnitude >= 10, tens=1 and ones=magnitude-10; otherwise tens=0 and ones=magnitude. Sign=1 only when sum<0, so zero is +0.
  - Go to RESP.
- RESP:
  - resp_valid=1 and resp_id/sum/bcd are held stable.
  - On resp_ready=1, go to IDLE next cycle and clear resp_valid.
  - The hold counter increments for each cycle spent in RESP with resp_ready=0. When HOLD_MAX != 0 and the counter reaches HOLD_MAX, pulse resp_drop for 1 cycle, clear resp_valid, and go to IDLE. The counter clears on leaving RESP.
- Latency: accept edge at cycle N; resp_valid=1 from cycle N+2. Minimum throughput is one result per 3 cycles.
- No accept happens outside IDLE. A request that stays valid while the block is busy stays pending and does not lose its priority turn.
- Requesters may change operands while not ready; only values at the accept edge are used.
- Reset asserted in CALC or RESP aborts the operation. No resp_valid and no resp_drop are produced for it.
- resp_ready=1 in the same cycle the counter hits HOLD_MAX: the transfer wins and there is no drop.
- Outputs resp_id/sum/bcd keep their last values when resp_valid=0.

Test Plan:
- Reset with RR_INIT=0; both requesters valid, req0=(3,4) and req1=(-8,-8) -> req0 granted first. Response id=0, sum=7, bcd=0_0_0111. Then id=1, sum=-16, bcd=1_1_0110.
- Single requester 1, a=-3, b=-4, resp_ready held 1 -> accept at N, resp_valid at N+2, sum=-7 (5'b11001), bcd=1_0_0111. Back in IDLE at N+3.
- Both requesters continuously valid for 6 transactions -> grants alternate 0,1,0,1,0,1 and no requester is starved.
- a=7, b=7 -> sum=14, bcd=0_1_0100. a=-8, b=7 -> sum=-1, bcd=1_0_0001. a=0, b=0 -> bcd=0_0_0000.
- HOLD_MAX=3 with resp_ready=0 -> resp_drop pulses after 3 RESP cycles and resp_valid falls. Repeat with resp_ready=1 on the 3rd cycle -> normal transfer, no drop.
- Assert rst during CALC -> next cycle all outputs 0 and state IDLE. The pending request is re-arbitrated from RR_INIT after reset is released.

Source files
------------

// File: rtl/add_share_arbiter_if.sv
// ============================================================================
// add_share_arbiter_if : requester and response channels of add_share_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

interface add_share_arbiter_if;
  logic       req0_valid;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req0_ready;
  logic       req1_valid;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       req1_ready;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_id;
  logic [4:0] resp_sum;
  logic [5:0] resp_bcd;
  logic       resp_drop;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    input  resp_ready,
    output resp_valid, resp_id, resp_sum, resp_bcd, resp_drop
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    output resp_ready,
    input  resp_valid, resp_id, resp_sum, resp_bcd, resp_drop
  );
endinterface

`default_nettype wire

// File: rtl/add_share_arbiter.sv
// ============================================================================
// add_share_arbiter : round-robin shared 4-bit signed adder with BCD result
// Revision 1.0
// ============================================================================
`default_nettype none

module add_share_arbiter #(
  parameter int RR_INIT  = 0,
  parameter int HOLD_MAX = 15
) (
  input  wire logic          clk,
  input  wire logic          rst,
  add_share_arbiter_if.slave bus
);

  localparam int c_hold_w = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_MAX - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  logic [1:0]          r_state;
  logic                r_ptr;
  logic [3:0]          r_a;
  logic [3:0]          r_b;
  logic                r_id;
  logic [c_hold_w-1:0] r_hold;
  logic                r_resp_valid;
  logic                r_resp_id;
  logic [4:0]          r_resp_sum;
  logic [5:0]          r_resp_bcd;
  logic                r_resp_drop;

  logic       w_idle;
  logic       w_gnt0;
  logic       w_gnt1;
  logic [4:0] w_sum;
  logic [4:0] w_mag;
  logic       w_tens;
  logic [3:0] w_ones;
  logic       w_hold_hit;

  // Ties go to the pointer; a lone valid requester always wins.
  assign w_idle = (r_state == c_st_idle) & ~rst;
  assign w_gnt0 = w_idle & bus.req0_valid & (~bus.req1_valid | ~r_ptr);
  assign w_gnt1 = w_idle & bus.req1_valid & (~bus.req0_valid |  r_ptr);

  assign w_sum  = {r_a[3], r_a} + {r_b[3], r_b};
  assign w_mag  = w_sum[4] ? (5'd0 - w_sum) : w_sum;
  assign w_tens = (w_mag >= 5'd10);
  assign w_ones = w_tens ? 4'(w_mag - 5'd10) : w_mag[3:0];

  // Counter reaches HOLD_MAX on the edge that ends this unready cycle.
  assign w_hold_hit = (HOLD_MAX != 0) && (r_hold == c_hold_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_ptr        <= 1'(RR_INIT);
      r_a          <= 4'd0;
      r_b          <= 4'd0;
      r_id         <= 1'b0;
      r_hold       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_sum   <= 5'd0;
      r_resp_bcd   <= 6'd0;
      r_resp_drop  <= 1'b0;
    end else begin
      r_resp_drop <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_gnt0 | w_gnt1) begin
            r_a     <= w_gnt1 ? bus.req1_a : bus.req0_a;
            r_b     <= w_gnt1 ? bus.req1_b : bus.req0_b;
            r_id    <= w_gnt1;
            r_ptr   <= ~w_gnt1;
            r_state <= c_st_calc;
          end
        end
        c_st_calc: begin
          r_resp_sum   <= w_sum;
          r_resp_bcd   <= {w_sum[4], w_tens, w_ones};
          r_resp_id    <= r_id;
          r_resp_valid <= 1'b1;
          r_hold       <= '0;
          r_state      <= c_st_resp;
        end
        c_st_resp: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_hold       <= '0;
            r_state      <= c_st_idle;
          end else if (w_hold_hit) begin
            r_resp_valid <= 1'b0;
            r_resp_drop  <= 1'b1;
            r_hold       <= '0;
            r_state      <= c_st_idle;
          end else begin
            r_hold <= r_hold + c_hold_w'(1);
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_sum   = r_resp_sum;
  assign bus.resp_bcd   = r_resp_bcd;
  assign bus.resp_drop  = r_resp_drop;

endmodule

`default_nettype wire

// File: tb/tb_add_share_arbiter.sv
// ============================================================================
// tb_add_share_arbiter : directed self-checking bench for add_share_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_add_share_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  add_share_arbiter_if bus();

  add_share_arbiter #(.RR_INIT(0), .HOLD_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = 4'd0; bus.req0_b = 4'd0;
    bus.req1_valid = 1'b0; bus.req1_a = 4'd0; bus.req1_b = 4'd0;
  endtask

  // Stimulus only: sole requester, resp_ready=1; returns {id,sum,bcd}.
  task automatic run_txn(input logic id, input logic [3:0] a, input logic [3:0] b,
                         output bit ok, output logic [11:0] res);
    if (id) begin bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; end
    else    begin bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; end
    tick();
    idle_inputs();
    ok  = 1'b0;
    res = 12'd0;
    for (int i = 0; i < 6 && !ok; i++) begin
      tick();
      if (bus.resp_valid) begin
        ok  = 1'b1;
        res = {bus.resp_id, bus.resp_sum, bus.resp_bcd};
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.resp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_drop, bus.resp_id, bus.resp_sum, bus.resp_bcd} !== 14'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0",
        {bus.resp_valid, bus.resp_drop, bus.resp_id, bus.resp_sum, bus.resp_bcd});
    end
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready: got %b want 00", {bus.req0_ready, bus.req1_ready});
    end
  endtask

  task automatic test_priority();
    bus.req0_valid = 1'b1; bus.req0_a = 4'd3;      bus.req0_b = 4'd4;
    bus.req1_valid = 1'b1; bus.req1_a = 4'b1000;   bus.req1_b = 4'b1000;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL prio_grant0: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    bus.req0_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp_valid} !== 3'b000) begin
      n_err++; $display("FAIL prio_calc_busy: got %b want 000",
        {bus.req0_ready, bus.req1_ready, bus.resp_valid});
    end
    tick();
    n_cmp++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_bcd} !== {1'b1, 1'b0, 5'd7, 6'b000111}) begin
      n_err++; $display("FAIL prio_resp0: got %h want %h",
        {bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_bcd}, {1'b1, 1'b0, 5'd7, 6'b000111});
    end
    tick();
    n_cmp++;
    if ({bus.resp_valid, bus.req1_ready} !== 2'b01) begin
      n_err++; $display("FAIL prio_grant1: got %b want 01", {bus.resp_valid, bus.req1_ready});
    end
    tick();
    bus.req1_valid = 1'b0;
    tick();
    n_cmp++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_bcd} !== {1'b1, 1'b1, 5'b10000, 6'b110110}) begin
      n_err++; $display("FAIL prio_resp1: got %h want %h",
        {bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_bcd}, {1'b1, 1'b1, 5'b10000, 6'b110110});
    end
    tick();
    n_cmp++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_bcd} !== {1'b0, 1'b1, 5'b10000, 6'b110110}) begin
      n_err++; $display("FAIL prio_hold_last: got %h want %h",
        {bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_bcd}, {1'b0, 1'b1, 5'b10000, 6'b110110});
    end
  endtask

  task automatic test_latency();
    bus.req1_valid = 1'b1; bus.req1_a = 4'b1101; bus.req1_b = 4'b1100;
    #1;
    n_cmp++;
    if (bus.req1_ready !== 1'b1) begin
      n_err++; $display("FAIL lat_single_grant: got %b want 1", bus.req1_ready);
    end
    tick();
    idle_inputs();
    n_cmp++;
    if (bus.resp_valid !== 1'b0) begin
      n_err++; $display("FAIL lat_n1_valid: got %b want 0", bus.resp_valid);
    end
    tick();
    n_cmp++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_bcd} !== {1'b1, 1'b1, 5'b11001, 6'b100111}) begin
      n_err++; $display("FAIL lat_n2_resp: got %h want %h",
        {bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_bcd}, {1'b1, 1'b1, 5'b11001, 6'b100111});
    end
    tick();
    bus.req0_valid = 1'b1;
    #1;
    n_cmp++;
    if ({bus.resp_valid, bus.req0_ready} !== 2'b01) begin
      n_err++; $display("FAIL lat_n3_idle: got %b want 01", {bus.resp_valid, bus.req0_ready});
    end
    bus.req0_valid = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back();
    int k;
    k = 0;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd2;
    bus.req1_valid = 1'b1; bus.req1_a = 4'd2; bus.req1_b = 4'd3;
    for (int c = 0; c < 40 && k < 6; c++) begin
      tick();
      if (bus.resp_valid) begin
        n_cmp++;
        if ({bus.resp_id, bus.resp_sum} !== ((k % 2) ? {1'b1, 5'd5} : {1'b0, 5'd3})) begin
          n_err++; $display("FAIL rr_result%0d: got %h want %h", k,
            {bus.resp_id, bus.resp_sum}, ((k % 2) ? {1'b1, 5'd5} : {1'b0, 5'd3}));
        end
        k++;
      end
    end
    idle_inputs();
    n_cmp++;
    if (k !== 6) begin
      n_err++; $display("FAIL rr_count: got %0d want 6", k);
    end
    tick();
  endtask

  task automatic test_values();
    logic [3:0]  va [3] = '{4'd7, 4'b1000, 4'd0};
    logic [3:0]  vb [3] = '{4'd7, 4'd7,    4'd0};
    logic [11:0] ve [3] = '{{1'b0, 5'd14, 6'b010100},
                            {1'b0, 5'b11111, 6'b100001},
                            {1'b0, 5'd0, 6'b000000}};
    bit          ok;
    logic [11:0] res;
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, va[i], vb[i], ok, res);
      n_cmp++;
      if (!ok || res !== ve[i]) begin
        n_err++; $display("FAIL value%0d: got %h (seen=%0d) want %h", i, res, ok, ve[i]);
      end
    end
  endtask

  task automatic test_hold();
    bus.resp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
    tick();
    idle_inputs();
    tick(); tick(); tick();
    n_cmp++;
    if ({bus.resp_valid, bus.resp_drop} !== 2'b10) begin
      n_err++; $display("FAIL hold_third_cycle: got %b want 10", {bus.resp_valid, bus.resp_drop});
    end
    tick();
    n_cmp++;
    if ({bus.resp_valid, bus.resp_drop} !== 2'b01) begin
      n_err++; $display("FAIL hold_drop: got %b want 01", {bus.resp_valid, bus.resp_drop});
    end
    tick();
    n_cmp++;
    if ({bus.resp_valid, bus.resp_drop} !== 2'b00) begin
      n_err++; $display("FAIL hold_drop_pulse: got %b want 00", {bus.resp_valid, bus.resp_drop});
    end
    bus.req0_valid = 1'b1; bus.req0_a = 4'd2; bus.req0_b = 4'd0;
    tick();
    idle_inputs();
    tick(); tick(); tick();
    bus.resp_ready = 1'b1;
    tick();
    n_cmp++;
    if ({bus.resp_valid, bus.resp_drop} !== 2'b00) begin
      n_err++; $display("FAIL hold_late_ready: got %b want 00", {bus.resp_valid, bus.resp_drop});
    end
    tick();
    n_cmp++;
    if (bus.resp_drop !== 1'b0) begin
      n_err++; $display("FAIL hold_no_drop: got %b want 0", bus.resp_drop);
    end
  endtask

  task automatic test_reset_calc();
    bit          ok;
    logic [11:0] res;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd5; bus.req0_b = 4'd1;
    bus.req1_valid = 1'b1; bus.req1_a = 4'd4; bus.req1_b = 4'd4;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      n_err++; $display("FAIL rstc_pre_grant: got %b want 01", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({bus.resp_valid, bus.resp_drop, bus.resp_id, bus.resp_sum, bus.resp_bcd} !== 14'd0) begin
      n_err++; $display("FAIL rstc_outputs: got %h want 0",
        {bus.resp_valid, bus.resp_drop, bus.resp_id, bus.resp_sum, bus.resp_bcd});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL rstc_rearb: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    bus.req1_valid = 1'b0;
    run_txn(1'b0, 4'd5, 4'd1, ok, res);
    n_cmp++;
    if (!ok || res !== {1'b0, 5'd6, 6'b000110}) begin
      n_err++; $display("FAIL rstc_after: got %h (seen=%0d) want %h", res, ok, {1'b0, 5'd6, 6'b000110});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_priority();
    test_latency();
    test_back_to_back();
    test_values();
    test_hold();
    test_reset_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
